// File: rtl/us_pkg.sv
// Shared definitions for the uplink frame parser: header layout, FSM states, error flag bits.
package us_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
  localparam logic [15:0] MAX_LEN_DEF   = 16'd1024;
  localparam int          CNT_W_DEF     = 32;

  localparam int HDR_SYNC_MSB = 127;
  localparam int HDR_SYNC_LSB = 112;
  localparam int HDR_ADDR_MSB = 111;
  localparam int HDR_ADDR_LSB = 88;
  localparam int HDR_LEN_MSB  = 87;
  localparam int HDR_LEN_LSB  = 72;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PAY  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int ERR_HDR   = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_OVR   = 2;
  localparam int ERR_RUNT  = 3;

  function automatic logic len_legal(input logic [15:0] len, input logic [15:0] max_len);
    return (len != 16'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/us_frame_parser.sv
// Strips uplink frame headers, forwards payload beats with the frame's cache address; optional stats (US_PARSER_STAT_EN).
// Latency: 1 cycle from accepted payload beat to us_timming_valid_o/us_timming_data_o.
// Backpressure: s_ready_o drops combinationally with dst_full_i in PAY only; HDR/DROP always accept.
module us_frame_parser
  import us_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter logic [15:0] MAX_LEN   = MAX_LEN_DEF,
  parameter int          CNT_W     = CNT_W_DEF
) (
  input  logic               sys_clk_i,
  input  logic               rst_n_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [127:0]       s_data_i,
  input  logic               s_last_i,
  input  logic               dst_full_i,
  output logic [23:0]        wr_current_cache_addr_o,
  output logic               us_timming_valid_o,
  output logic [127:0]       us_timming_data_o,
  output logic [CNT_W-1:0]   frame_ok_cnt_o,
  output logic [CNT_W-1:0]   frame_err_cnt_o,
  output logic [3:0]         err_flags_o
);

  state_e      state_q, state_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        run_q;
  logic        s_fire;
  logic        load_addr;
  logic        fwd;
  logic [3:0]  flag_set;

  logic [15:0] hdr_sync;
  logic [23:0] hdr_addr;
  logic [15:0] hdr_len;
  logic        hdr_good;

  assign hdr_sync = s_data_i[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_addr = s_data_i[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_len  = s_data_i[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_good = (hdr_sync == SYNC_WORD) && len_legal(hdr_len, MAX_LEN);
  assign s_fire   = s_valid_i & s_ready_o;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    s_ready_o  = 1'b0;
    load_addr  = 1'b0;
    fwd        = 1'b0;
    flag_set   = 4'b0000;
    case (state_q)
      ST_HDR: begin
        s_ready_o = run_q;
        if (s_fire) begin
          if (!hdr_good) begin
            flag_set[ERR_HDR] = 1'b1;
            if (!s_last_i) state_d = ST_DROP;
          end else if (s_last_i) begin
            flag_set[ERR_RUNT] = 1'b1;
          end else begin
            load_addr  = 1'b1;
            beat_cnt_d = hdr_len;
            state_d    = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        s_ready_o = run_q & ~dst_full_i;
        if (s_fire) begin
          fwd = 1'b1;
          // Counter leaves PAY at 1, so the decrement can never wrap.
          beat_cnt_d = beat_cnt_q - 16'd1;
          if (beat_cnt_q == 16'd1) begin
            if (s_last_i) begin
              state_d = ST_HDR;
            end else begin
              flag_set[ERR_OVR] = 1'b1;
              state_d = ST_DROP;
            end
          end else if (s_last_i) begin
            flag_set[ERR_TRUNC] = 1'b1;
            state_d = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        s_ready_o = run_q;
        if (s_fire && s_last_i) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q                 <= ST_HDR;
      beat_cnt_q              <= 16'd0;
      run_q                   <= 1'b0;
      wr_current_cache_addr_o <= 24'd0;
      us_timming_valid_o      <= 1'b0;
      us_timming_data_o       <= 128'd0;
      err_flags_o             <= 4'b0000;
    end else begin
      state_q            <= state_d;
      beat_cnt_q         <= beat_cnt_d;
      run_q              <= 1'b1;
      us_timming_valid_o <= fwd;
      err_flags_o        <= err_flags_o | flag_set;
      if (load_addr) wr_current_cache_addr_o <= hdr_addr;
      if (fwd)       us_timming_data_o       <= s_data_i;
    end
  end

`ifdef US_PARSER_STAT_EN
  logic ok_evt;
  logic err_evt;

  // Every header accepted with s_last_i is either a bad header or a runt, so it always ends in error.
  assign ok_evt  = s_fire && s_last_i && (state_q == ST_PAY) && (beat_cnt_q == 16'd1);
  assign err_evt = s_fire && s_last_i &&
                   ((state_q == ST_HDR) || (state_q == ST_DROP) ||
                    ((state_q == ST_PAY) && (beat_cnt_q != 16'd1)));

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_ok_cnt_o  <= '0;
      frame_err_cnt_o <= '0;
    end else begin
      if (ok_evt && (frame_ok_cnt_o != {CNT_W{1'b1}}))
        frame_ok_cnt_o <= frame_ok_cnt_o + 1'b1;
      if (err_evt && (frame_err_cnt_o != {CNT_W{1'b1}}))
        frame_err_cnt_o <= frame_err_cnt_o + 1'b1;
    end
  end
`else
  assign frame_ok_cnt_o  = '0;
  assign frame_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_us_frame_parser.sv
// Self-checking bench for us_frame_parser: vector table plus stall and mid-frame reset sequences.
module tb_us_frame_parser;

  localparam logic [15:0] SW = 16'hEB90;
`ifdef US_PARSER_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         dst_full = 1'b0;
  logic [23:0]  addr;
  logic         vld;
  logic [127:0] dat;
  logic [31:0]  ok_cnt, err_cnt;
  logic [3:0]   flags;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  us_frame_parser dut (
    .sys_clk_i               (clk),
    .rst_n_i                 (rst_n),
    .s_valid_i               (s_valid),
    .s_ready_o               (s_ready),
    .s_data_i                (s_data),
    .s_last_i                (s_last),
    .dst_full_i              (dst_full),
    .wr_current_cache_addr_o (addr),
    .us_timming_valid_o      (vld),
    .us_timming_data_o       (dat),
    .frame_ok_cnt_o          (ok_cnt),
    .frame_err_cnt_o         (err_cnt),
    .err_flags_o             (flags)
  );

  typedef struct {
    logic [127:0] dat;
    logic         last;
    logic         fwd;
    logic [23:0]  addr;
    logic [3:0]   flags;
    int           ok;
    int           err;
  } vec_t;

  typedef struct {
    logic [127:0] dat;
    logic [23:0]  addr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [127:0] hdr(input logic [15:0] sync, input logic [23:0] a,
                                       input logic [15:0] len);
    return {sync, a, len, 72'h0};
  endfunction

  function automatic logic [127:0] pay(input int n);
    return {32'hA5A5_0000 + n, 32'h1234_5678, 32'(n * 7), 32'hC0DE_0000 | n};
  endfunction

  function automatic int exp_cnt(input int n);
    return STAT_EN ? n : 0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  task automatic add(input logic [127:0] d, input logic l, input logic f, input logic [23:0] a,
                     input logic [3:0] fl, input int ok, input int err);
    vec_t v;
    v.dat = d; v.last = l; v.fwd = f; v.addr = a; v.flags = fl; v.ok = ok; v.err = err;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [127:0] d, input logic l, input logic f, input logic [23:0] a);
    bit done;
    exp_t e;
    done = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int budget = 0; budget < 50; budget++) begin
      #1;
      if (s_ready) begin
        if (f) begin
          e.dat = d; e.addr = a;
          sb.push_back(e);
        end
        @(posedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ready_timeout", 128'(done), 128'(1));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 128'(vld), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("beat_data", dat, mon_e.dat);
        chk("beat_addr", 128'(addr), 128'(mon_e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame 1: LEN=4
    add(hdr(SW, 24'h000103, 4), 0, 0, 24'h103, 4'h0, 0, 0);
    add(pay(1), 0, 1, 24'h103, 4'h0, 0, 0);
    add(pay(2), 0, 1, 24'h103, 4'h0, 0, 0);
    add(pay(3), 0, 1, 24'h103, 4'h0, 0, 0);
    add(pay(4), 1, 1, 24'h103, 4'h0, 1, 0);
    // Back-to-back frames
    add(hdr(SW, 24'h10, 2), 0, 0, 24'h10, 4'h0, 1, 0);
    add(pay(11), 0, 1, 24'h10, 4'h0, 1, 0);
    add(pay(12), 1, 1, 24'h10, 4'h0, 2, 0);
    add(hdr(SW, 24'h20, 2), 0, 0, 24'h20, 4'h0, 2, 0);
    add(pay(21), 0, 1, 24'h20, 4'h0, 2, 0);
    add(pay(22), 1, 1, 24'h20, 4'h0, 3, 0);
    // Bad sync, 3-beat frame
    add(hdr(16'h1234, 24'h55, 3), 0, 0, 24'h20, 4'h1, 3, 0);
    add(pay(31), 0, 0, 24'h20, 4'h1, 3, 0);
    add(pay(32), 1, 0, 24'h20, 4'h1, 3, 1);
    // Truncated
    add(hdr(SW, 24'h30, 3), 0, 0, 24'h30, 4'h1, 3, 1);
    add(pay(41), 0, 1, 24'h30, 4'h1, 3, 1);
    add(pay(42), 1, 1, 24'h30, 4'h3, 3, 2);
    // Overrun
    add(hdr(SW, 24'h40, 2), 0, 0, 24'h40, 4'h3, 3, 2);
    add(pay(51), 0, 1, 24'h40, 4'h3, 3, 2);
    add(pay(52), 0, 1, 24'h40, 4'h7, 3, 2);
    add(pay(53), 0, 0, 24'h40, 4'h7, 3, 2);
    add(pay(54), 1, 0, 24'h40, 4'h7, 3, 3);
    // Runt, LEN=0, LEN=MAX+1, LEN=MAX runt, LEN=1
    add(hdr(SW, 24'h77, 5), 1, 0, 24'h40, 4'hF, 3, 4);
    add(hdr(SW, 24'h78, 0), 1, 0, 24'h40, 4'hF, 3, 5);
    add(hdr(SW, 24'h79, 1025), 0, 0, 24'h40, 4'hF, 3, 5);
    add(pay(61), 1, 0, 24'h40, 4'hF, 3, 6);
    add(hdr(SW, 24'h50, 1024), 1, 0, 24'h40, 4'hF, 3, 7);
    add(hdr(SW, 24'h51, 1), 0, 0, 24'h51, 4'hF, 3, 7);
    add(pay(71), 1, 1, 24'h51, 4'hF, 4, 7);

    // Reset state
    #2;
    chk("rst_ready", 128'(s_ready), 128'(0));
    chk("rst_valid", 128'(vld), 128'(0));
    chk("rst_addr", 128'(addr), 128'(0));
    chk("rst_data", dat, 128'(0));
    chk("rst_flags", 128'(flags), 128'(0));
    chk("rst_ok", 128'(ok_cnt), 128'(0));
    chk("rst_err", 128'(err_cnt), 128'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].dat, vecs[i].last, vecs[i].fwd, vecs[i].addr);
      chk($sformatf("v%0d_addr", i), 128'(addr), 128'(vecs[i].addr));
      chk($sformatf("v%0d_flags", i), 128'(flags), 128'(vecs[i].flags));
      chk($sformatf("v%0d_ok", i), 128'(ok_cnt), 128'(exp_cnt(vecs[i].ok)));
      chk($sformatf("v%0d_err", i), 128'(err_cnt), 128'(exp_cnt(vecs[i].err)));
    end

    // dst_full stall mid-PAY
    send(hdr(SW, 24'h60, 4), 0, 0, 24'h60);
    send(pay(81), 0, 1, 24'h60);
    dst_full = 1'b1;
    s_valid = 1'b1; s_data = pay(82); s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready", 128'(s_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("stall_valid", 128'(vld), 128'(0));
      @(negedge clk);
    end
    dst_full = 1'b0;
    send(pay(82), 0, 1, 24'h60);
    send(pay(83), 0, 1, 24'h60);
    send(pay(84), 1, 1, 24'h60);
    chk("stall_ok", 128'(ok_cnt), 128'(exp_cnt(5)));
    chk("stall_addr", 128'(addr), 128'(24'h60));

    // Reset in the middle of PAY, right after a beat was forwarded
    send(hdr(SW, 24'h70, 3), 0, 0, 24'h70);
    send(pay(91), 0, 1, 24'h70);
    s_valid = 1'b1; s_data = pay(92); s_last = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    s_valid = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 128'(vld), 128'(0));
    chk("mid_rst_data", dat, 128'(0));
    chk("mid_rst_addr", 128'(addr), 128'(0));
    chk("mid_rst_flags", 128'(flags), 128'(0));
    chk("mid_rst_ready", 128'(s_ready), 128'(0));
    chk("mid_rst_ok", 128'(ok_cnt), 128'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(hdr(SW, 24'h71, 2), 0, 0, 24'h71);
    send(pay(101), 0, 1, 24'h71);
    send(pay(102), 1, 1, 24'h71);
    chk("post_rst_addr", 128'(addr), 128'(24'h71));
    chk("post_rst_flags", 128'(flags), 128'(0));
    chk("post_rst_ok", 128'(ok_cnt), 128'(exp_cnt(1)));
    chk("post_rst_err", 128'(err_cnt), 128'(0));

    @(negedge clk); @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
